rat_io_ctrl: RTL
================

Name: rat_io_ctrl

Overview:
Port-mapped I/O peripheral on the RAT MCU port bus. Consumes PORT_ID/OUT_PORT/IO_STRB to latch output registers. Drives the IN_PORT read mux. Generates the level interrupt INT_CU from a debounced push-button and a programmable interval timer; pending interrupts are cleared by software acknowledge.

Parameters:
DB_COUNT, 20'd500000, stable cycles required before a debounced button edge is accepted (5 ms at 100 MHz)
TMR_PRESCALE, 17'd100000, CLK cycles per timer tick (1 ms at 100 MHz)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
PORT_ID  in  8  port address from MCU
OUT_PORT  in  8  write data from MCU
IO_STRB  in  1  write strobe; one CLK high per OUT instruction
SWITCHES  in  8  board switches, quasi-static, not synchronised
BTN  in  1  raw asynchronous push-button
IN_PORT  out  8  read data to MCU, combinational on PORT_ID
INT_CU  out  1  level interrupt request to MCU
LEDS  out  16  LED output register

Behaviour:
- Single clock domain CLK; RESET synchronous active-high, all state updates on rising CLK edge.
- Port map, reads (combinational, zero latency): 0x20 SWITCHES; 0x21 STATUS = {4'b0, tmr_en, btn_level, tmr_pend, btn_pend}; 0x22 LEDS[7:0]; 0x23 LEDS[15:8]; any other ID -> 0x00.
- Port map, writes (IO_STRB=1 and ID match, register updates at that edge): 0x40 LEDS[7:0]; 0x41 LEDS[15:8]; 0x42 INT_ACK: bit0 clears btn_pend, bit1 clears tmr_pend, other bits ignored; 0x43 INT_MASK[1:0] (bit0 btn, bit1 tmr); 0x44 TMR_PERIOD (ticks); unmapped write IDs ignored. IO_STRB=0: no register changes.
- Reset values: LEDS=0, INT_MASK=0, TMR_PERIOD=0, btn_pend=tmr_pend=0, INT_CU=0, debouncer in IDLE with btn_level=0, timer counters 0.
- Button path: 2-flop synchroniser on BTN, then debounce FSM:
  IDLE (level 0): sync=1 -> WAIT_HI, counter=0.
  WAIT_HI: sync=0 -> IDLE; counter==DB_COUNT-1 -> HIGH, assert 1-cycle press pulse; else counter++.
  HIGH (level 1): sync=0 -> WAIT_LO, counter=0.
  WAIT_LO: sync=1 -> HIGH; counter==DB_COUNT-1 -> IDLE; else counter++.
  btn_level=1 in HIGH and WAIT_LO.
- Press pulse sets btn_pend only if INT_MASK[0]=1; release sets nothing.
- Timer: tmr_en = (TMR_PERIOD!=0). Prescaler counts 0..TMR_PRESCALE-1, wraps, emits tick at wrap. Tick counter increments on tick; on reaching TMR_PERIOD-1 at a tick it wraps to 0 and sets tmr_pend if INT_MASK[1]=1. Write to 0x44 reloads both counters to 0 (same edge). TMR_PERIOD=0 holds both counters at 0.
- Simultaneous set and ACK clear of the same pending bit in one cycle: set wins (bit stays 1).
- INT_CU registered: INT_CU <= |(pend & INT_MASK), computed from next-state values, so INT_CU rises the cycle after the set event. Clearing a mask bit deasserts INT_CU next cycle, pending bit retained.
- RESET mid-debounce or mid-timer: everything returns to reset values at that edge; a held button must re-qualify for DB_COUNT cycles after reset.

Decomposition:
- Package rat_io_pkg: port-ID localparams (PID_SWITCHES=0x20, PID_STATUS=0x21, PID_LEDS_LO_RD=0x22, PID_LEDS_HI_RD=0x23, PID_LEDS_LO=0x40, PID_LEDS_HI=0x41, PID_INT_ACK=0x42, PID_INT_MASK=0x43, PID_TMR_PERIOD=0x44); typedef enum logic [1:0] db_state_t {IDLE, WAIT_HI, HIGH, WAIT_LO}.
- One sub-module: rat_debounce (synchroniser + FSM; outputs level and press pulse; parameter DB_COUNT). Timer, registers and read mux stay in rat_io_ctrl.

Test Plan:
- RESET 1 cycle -> LEDS=0x0000, INT_CU=0, IN_PORT=0x00 with PORT_ID=0x21; SWITCHES=0xA5, PORT_ID=0x20 -> IN_PORT=0xA5 same cycle; PORT_ID=0x7F -> 0x00.
- IO_STRB pulse ID=0x40 data=0x3C, then ID=0x41 data=0xC3 -> LEDS=0xC33C; same writes with IO_STRB=0 -> LEDS unchanged.
- DB_COUNT=4, mask=0x01: BTN high 3 cycles then low -> no btn_pend; BTN high 10 cycles -> btn_pend=1, INT_CU=1 one cycle later, STATUS=0x05; write 0x01 to 0x42 -> INT_CU=0 next cycle.
- TMR_PRESCALE=2, mask=0x02, TMR_PERIOD=3 -> tmr_pend sets 6 cycles after the period write, STATUS bit1=1; TMR_PERIOD=0 -> no further sets.
- ACK write to 0x42 data=0x02 on the same cycle as timer expiry -> tmr_pend stays 1, INT_CU stays 1.
- RESET asserted while debouncer in WAIT_HI and INT_CU=1 -> INT_CU=0, LEDS=0; BTN held high -> btn_pend needs a full DB_COUNT qualification again.

Source files
------------

// File: rtl/rat_io_ctrl_pkg.sv
// RAT port-bus I/O peripheral: shared port map and debouncer state type.
// Imported by the debouncer and the I/O controller top.
package rat_io_pkg;

  localparam logic [7:0] PID_SWITCHES   = 8'h20;
  localparam logic [7:0] PID_STATUS     = 8'h21;
  localparam logic [7:0] PID_LEDS_LO_RD = 8'h22;
  localparam logic [7:0] PID_LEDS_HI_RD = 8'h23;
  localparam logic [7:0] PID_LEDS_LO    = 8'h40;
  localparam logic [7:0] PID_LEDS_HI    = 8'h41;
  localparam logic [7:0] PID_INT_ACK    = 8'h42;
  localparam logic [7:0] PID_INT_MASK   = 8'h43;
  localparam logic [7:0] PID_TMR_PERIOD = 8'h44;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    HIGH,
    WAIT_LO
  } db_state_t;

endpackage

// File: rtl/rat_io_ctrl_if.sv
// RAT MCU port bus: address/data/strobe from the MCU,
// read data and interrupt request back to it.
interface rat_io_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_PORT;
  logic       INT_CU;

  modport master (
    output PORT_ID, OUT_PORT, IO_STRB,
    input  IN_PORT, INT_CU
  );

  modport slave (
    input  PORT_ID, OUT_PORT, IO_STRB,
    output IN_PORT, INT_CU
  );
endinterface

// File: rtl/rat_io_ctrl_debounce.sv
// Push-button synchroniser and debounce FSM.
// Emits the debounced level and a one-cycle press pulse.
module rat_debounce
  import rat_io_pkg::*;
#(
  parameter logic [19:0] DB_COUNT = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  logic        s1;
  logic        s2;
  db_state_t   st;
  db_state_t   st_d;
  logic [19:0] cnt;
  logic [19:0] cnt_d;
  logic        done;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= IDLE;
      cnt <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      st  <= st_d;
      cnt <= cnt_d;
    end
  end

  assign done = (cnt == DB_COUNT - 20'd1);

  always_comb begin
    st_d  = st;
    cnt_d = cnt;
    press = 1'b0;
    unique case (st)
      IDLE: begin
        if (s2) begin
          st_d  = WAIT_HI;
          cnt_d = '0;
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          st_d = IDLE;
        end else if (done) begin
          st_d  = HIGH;
          press = 1'b1;
        end else begin
          cnt_d = cnt + 20'd1;
        end
      end
      HIGH: begin
        if (!s2) begin
          st_d  = WAIT_LO;
          cnt_d = '0;
        end
      end
      WAIT_LO: begin
        if (s2) begin
          st_d = HIGH;
        end else if (done) begin
          st_d = IDLE;
        end else begin
          cnt_d = cnt + 20'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign level = (st == HIGH) || (st == WAIT_LO);

endmodule

// File: rtl/rat_io_ctrl.sv
// Port-mapped I/O peripheral: LED registers, read mux, and the
// button/timer interrupt sources with software acknowledge.
module rat_io_ctrl
  import rat_io_pkg::*;
#(
  parameter logic [19:0] DB_COUNT     = 20'd500000,
  parameter logic [16:0] TMR_PRESCALE = 17'd100000
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [7:0]   SWITCHES,
  input  logic         BTN,
  output logic [15:0]  LEDS,
  rat_io_ctrl_if.slave bus
);

  logic        btn_level;
  logic        press;
  logic [1:0]  mask;
  logic [1:0]  mask_d;
  logic [7:0]  period;
  logic [16:0] pre;
  logic [16:0] pre_d;
  logic [7:0]  tcnt;
  logic [7:0]  tcnt_d;
  logic [1:0]  pend;
  logic [1:0]  pend_d;
  logic [1:0]  ack;
  logic        int_q;
  logic        tmr_en;
  logic        tick;
  logic        tmr_set;
  logic        we_lo;
  logic        we_hi;
  logic        we_ack;
  logic        we_mask;
  logic        we_per;
  logic [7:0]  rd;

  rat_debounce #(.DB_COUNT(DB_COUNT)) u_db (
    .clk   (CLK),
    .rst   (RESET),
    .btn   (BTN),
    .level (btn_level),
    .press (press)
  );

  always_comb begin
    we_lo   = 1'b0;
    we_hi   = 1'b0;
    we_ack  = 1'b0;
    we_mask = 1'b0;
    we_per  = 1'b0;
    if (bus.IO_STRB) begin
      unique case (bus.PORT_ID)
        PID_LEDS_LO:    we_lo   = 1'b1;
        PID_LEDS_HI:    we_hi   = 1'b1;
        PID_INT_ACK:    we_ack  = 1'b1;
        PID_INT_MASK:   we_mask = 1'b1;
        PID_TMR_PERIOD: we_per  = 1'b1;
        default: ;
      endcase
    end
  end

  assign tmr_en = (period != 8'd0);
  assign tick   = (pre == TMR_PRESCALE - 17'd1);

  // A period write restarts the interval from zero on the same edge.
  always_comb begin
    pre_d   = pre;
    tcnt_d  = tcnt;
    tmr_set = 1'b0;
    if (we_per || !tmr_en) begin
      pre_d  = '0;
      tcnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (tcnt == period - 8'd1) begin
        tcnt_d  = '0;
        tmr_set = mask[1];
      end else begin
        tcnt_d = tcnt + 8'd1;
      end
    end else begin
      pre_d = pre + 17'd1;
    end
  end

  // Set beats a same-cycle acknowledge.
  assign ack    = {2{we_ack}} & bus.OUT_PORT[1:0];
  assign pend_d = {tmr_set, press & mask[0]} | (pend & ~ack);
  assign mask_d = we_mask ? bus.OUT_PORT[1:0] : mask;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS   <= '0;
      mask   <= '0;
      period <= '0;
      pre    <= '0;
      tcnt   <= '0;
      pend   <= '0;
      int_q  <= 1'b0;
    end else begin
      if (we_lo) LEDS[7:0]  <= bus.OUT_PORT;
      if (we_hi) LEDS[15:8] <= bus.OUT_PORT;
      if (we_per) period    <= bus.OUT_PORT;
      mask  <= mask_d;
      pre   <= pre_d;
      tcnt  <= tcnt_d;
      pend  <= pend_d;
      int_q <= |(pend_d & mask_d);
    end
  end

  always_comb begin
    rd = 8'h00;
    unique case (bus.PORT_ID)
      PID_SWITCHES:   rd = SWITCHES;
      PID_STATUS:     rd = {4'b0, tmr_en, btn_level, pend[1], pend[0]};
      PID_LEDS_LO_RD: rd = LEDS[7:0];
      PID_LEDS_HI_RD: rd = LEDS[15:8];
      default:        rd = 8'h00;
    endcase
  end

  assign bus.IN_PORT = rd;
  assign bus.INT_CU  = int_q;

endmodule
